// File: rtl/ifetch_ucode_seq.sv
`default_nettype none
// ============================================================================
// Module : ifetch_ucode_seq
// Purpose: Instruction-fetch stage with a microcode sequencer. It issues
//          sequential and branch PCs and forwards fetched instructions to
//          decode over a valid/ready handshake. A fetched macro opcode that
//          matches the run-time table is expanded into a sequence read from an
//          external ucode ROM. The ROM sequence may contain one counted loop
//          and ends with an END marker. A taken branch resolved in execute
//          (exe_override) redirects the PC and aborts any running sequence.
// Ports  : clk, rst (async, active-high)
//          imem_instr/imem_valid            - instruction memory read data
//          program_counter                  - fetch address
//          ucode_addr/ucode_instr           - ucode ROM address and same-cycle data
//          macro_opc_tbl/macro_entry_tbl    - macro opcode table and ROM entry points
//          exe_override/exe_offset          - execute redirect and signed offset
//          out_instr/out_valid/out_ready    - handshake towards decode
//          ucode_flag                       - high while a sequence is running
//          macro_rd/macro_rs/macro_imm      - operand fields latched from the macro
// Option : `define UCODE_OPERAND_SUBST_EN substitutes the latched macro operands
//          into forwarded ucode instructions (rd/rs when the field is 4'hF,
//          imm when bit 16 is set).
// Rev    : 1.0 - initial release
// ============================================================================
module ifetch_ucode_seq #(
  parameter int PC_W    = 32,
  parameter int UADDR_W = 5,
  parameter int N_MACRO = 4,
  parameter int IMM_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                imem_instr,
  input  logic                       imem_valid,
  output logic [PC_W-1:0]            program_counter,
  output logic [UADDR_W-1:0]         ucode_addr,
  input  logic [31:0]                ucode_instr,
  input  logic [7*N_MACRO-1:0]       macro_opc_tbl,
  input  logic [UADDR_W*N_MACRO-1:0] macro_entry_tbl,
  input  logic                       exe_override,
  input  logic [IMM_W-1:0]           exe_offset,
  output logic [31:0]                out_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       ucode_flag,
  output logic [3:0]                 macro_rd,
  output logic [3:0]                 macro_rs,
  output logic [15:0]                macro_imm
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_UCODE = 2'd2
  } state_t;

  state_t               state, next_state;
  logic [PC_W-1:0]      pc_next;
  logic [UADDR_W-1:0]   uaddr_next;
  logic [3:0]           rd_next, rs_next;
  logic [15:0]          imm_next;
  logic [7:0]           loop_cnt, cnt_next;
  logic                 loop_busy, busy_next;

  logic                 macro_hit;
  logic [UADDR_W-1:0]   macro_entry;
  logic                 is_branch;
  logic [PC_W-1:0]      exe_ext, br_ext;
  logic [31:0]          fwd_instr;
  logic [7:0]           loop_count;
  logic [UADDR_W-1:0]   loop_target;

  assign exe_ext     = PC_W'($signed(exe_offset));
  assign br_ext      = PC_W'($signed(imem_instr[15:0]));
  assign is_branch   = (imem_instr[31:30] == 2'b11) && (imem_instr[28:25] == 4'b0000);
  assign loop_count  = ucode_instr[15:8];
  assign loop_target = ucode_instr[UADDR_W-1:0];

  // Table search runs from the highest index down so the lowest matching
  // index is the last one written and therefore wins on duplicates.
  always_comb begin
    macro_hit   = 1'b0;
    macro_entry = '0;
    for (int i = N_MACRO - 1; i >= 0; i--) begin
      if (imem_instr[31:25] == macro_opc_tbl[7*i +: 7]) begin
        macro_hit   = 1'b1;
        macro_entry = macro_entry_tbl[UADDR_W*i +: UADDR_W];
      end
    end
    macro_hit = macro_hit & imem_valid;
  end

  // Instruction forwarded from the ROM, optionally with macro operands patched in.
  always_comb begin
    fwd_instr = ucode_instr;
`ifdef UCODE_OPERAND_SUBST_EN
    if (ucode_instr[24:21] == 4'hF) fwd_instr[24:21] = macro_rd;
    if (ucode_instr[20:17] == 4'hF) fwd_instr[20:17] = macro_rs;
    if (ucode_instr[16])            fwd_instr[15:0]  = macro_imm;
`endif
  end

  always_comb begin
    next_state = state;
    pc_next    = program_counter;
    uaddr_next = ucode_addr;
    rd_next    = macro_rd;
    rs_next    = macro_rs;
    imm_next   = macro_imm;
    cnt_next   = loop_cnt;
    busy_next  = loop_busy;
    out_instr  = 32'h0;
    out_valid  = 1'b0;
    ucode_flag = 1'b0;

    case (state)
      S_IDLE: begin
        next_state = S_FETCH;
      end

      S_FETCH: begin
        out_instr = imem_instr;
        out_valid = imem_valid & ~exe_override & ~macro_hit;
        if (exe_override) begin
          pc_next = program_counter + exe_ext;
        end else if (macro_hit) begin
          // Macro expansion starts without waiting for decode to be ready.
          rd_next    = imem_instr[24:21];
          rs_next    = imem_instr[20:17];
          imm_next   = imem_instr[15:0];
          uaddr_next = macro_entry;
          pc_next    = program_counter + PC_W'(4);
          next_state = S_UCODE;
        end else if (imem_valid && out_ready) begin
          if (is_branch) pc_next = program_counter + PC_W'(4) + br_ext;
          else           pc_next = program_counter + PC_W'(4);
        end
      end

      S_UCODE: begin
        ucode_flag = 1'b1;
        if (exe_override) begin
          pc_next    = program_counter + exe_ext;
          busy_next  = 1'b0;
          next_state = S_FETCH;
        end else begin
          case (ucode_instr[31:28])
            4'hD: begin
              busy_next  = 1'b0;
              next_state = S_FETCH;
            end
            4'hE: begin
              // First visit loads count-1; later visits count down, so the
              // body runs count+1 times. A zero count falls straight through.
              if (!loop_busy && loop_count != 8'd0) begin
                busy_next  = 1'b1;
                cnt_next   = loop_count - 8'd1;
                uaddr_next = loop_target;
              end else if (loop_busy && loop_cnt != 8'd0) begin
                cnt_next   = loop_cnt - 8'd1;
                uaddr_next = loop_target;
              end else begin
                busy_next  = 1'b0;
                uaddr_next = ucode_addr + UADDR_W'(1);
              end
            end
            default: begin
              out_instr = fwd_instr;
              out_valid = 1'b1;
              if (out_ready) uaddr_next = ucode_addr + UADDR_W'(1);
            end
          endcase
        end
      end

      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      program_counter <= '0;
      ucode_addr      <= '0;
      macro_rd        <= 4'h0;
      macro_rs        <= 4'h0;
      macro_imm       <= 16'h0;
      loop_cnt        <= 8'h0;
      loop_busy       <= 1'b0;
    end else begin
      state           <= next_state;
      program_counter <= pc_next;
      ucode_addr      <= uaddr_next;
      macro_rd        <= rd_next;
      macro_rs        <= rs_next;
      macro_imm       <= imm_next;
      loop_cnt        <= cnt_next;
      loop_busy       <= busy_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ucode_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_ifetch_ucode_seq
// Purpose: Directed, table-driven bench for ifetch_ucode_seq. The ucode ROM is
//          a bench array read combinationally at ucode_addr; the main table
//          covers sequential fetch, branch, back-pressure and a macro
//          expansion, and hand-written sequences cover loops, abort and
//          asynchronous reset mid-loop.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ifetch_ucode_seq;

  localparam int PC_W    = 32;
  localparam int UADDR_W = 5;
  localparam int N_MACRO = 4;
  localparam int IMM_W   = 16;

  localparam logic [31:0] ADD    = 32'h0000_0033;
  localparam logic [31:0] BR     = 32'hC000_FFF8;   // branch, imm = -8
  localparam logic [31:0] MACRO1 = 32'h206A_1234;   // opc 0010000, rd 3, rs 5, imm 1234
  localparam logic [31:0] MACRO0 = 32'h0200_0000;   // opc 0000001 (entries 0 and 3)
  localparam logic [31:0] I0     = 32'h1000_0A01;
  localparam logic [31:0] I1     = 32'h31E0_0C03;   // rd field = F
  localparam logic [31:0] UEND   = 32'hD000_0000;
`ifdef UCODE_OPERAND_SUBST_EN
  localparam logic [31:0] I1_EXP = 32'h3060_0C03;
`else
  localparam logic [31:0] I1_EXP = 32'h31E0_0C03;
`endif

  logic                       clk = 1'b0;
  logic                       rst;
  logic [31:0]                imem_instr;
  logic                       imem_valid;
  logic [PC_W-1:0]            program_counter;
  logic [UADDR_W-1:0]         ucode_addr;
  logic [31:0]                ucode_instr;
  logic [7*N_MACRO-1:0]       macro_opc_tbl;
  logic [UADDR_W*N_MACRO-1:0] macro_entry_tbl;
  logic                       exe_override;
  logic [IMM_W-1:0]           exe_offset;
  logic [31:0]                out_instr;
  logic                       out_valid;
  logic                       out_ready;
  logic                       ucode_flag;
  logic [3:0]                 macro_rd, macro_rs;
  logic [15:0]                macro_imm;

  logic [31:0] rom [0:31];
  assign ucode_instr = rom[ucode_addr];

  always #5 clk = ~clk;

  ifetch_ucode_seq #(
    .PC_W(PC_W), .UADDR_W(UADDR_W), .N_MACRO(N_MACRO), .IMM_W(IMM_W)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_instr(imem_instr), .imem_valid(imem_valid),
    .program_counter(program_counter),
    .ucode_addr(ucode_addr), .ucode_instr(ucode_instr),
    .macro_opc_tbl(macro_opc_tbl), .macro_entry_tbl(macro_entry_tbl),
    .exe_override(exe_override), .exe_offset(exe_offset),
    .out_instr(out_instr), .out_valid(out_valid), .out_ready(out_ready),
    .ucode_flag(ucode_flag),
    .macro_rd(macro_rd), .macro_rs(macro_rs), .macro_imm(macro_imm)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        ready;
    logic        ovr;
    logic [15:0] off;
    logic [31:0] e_pc;
    logic [4:0]  e_uaddr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_chk;     // compare out_instr on this row
    logic        e_flag;
  } vec_t;

  vec_t vecs [20];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [31:0] instr, input logic valid, input logic ready,
                              input logic ovr, input logic [15:0] off, input logic [31:0] e_pc,
                              input logic [4:0] e_uaddr, input logic e_valid,
                              input logic [31:0] e_instr, input logic e_chk, input logic e_flag);
    vec_t v;
    v.instr = instr; v.valid = valid; v.ready = ready; v.ovr = ovr; v.off = off;
    v.e_pc = e_pc; v.e_uaddr = e_uaddr; v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_chk = e_chk; v.e_flag = e_flag;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs macro 0 (entry 3) through ROM 3=I0, 4=LOOP(3,cnt), 5=END.
  task automatic run_loop(input logic [7:0] cnt, input int exp_issues, input logic [31:0] exp_pc);
    int issues;
    int cycles;
    rom[3] = I0;
    rom[4] = {4'hE, 12'h000, cnt, 8'h03};
    rom[5] = UEND;
    @(negedge clk);
    imem_instr = MACRO0; imem_valid = 1'b1; out_ready = 1'b1; exe_override = 1'b0;
    #1;
    check("loop macro not forwarded", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    imem_valid = 1'b0;
    #1;
    check("loop entry lowest index", {27'h0, ucode_addr}, 32'd3);
    check("loop ucode_flag", {31'h0, ucode_flag}, 32'h1);
    issues = 0;
    cycles = 0;
    while (ucode_flag && cycles < 40) begin
      if (out_valid && out_ready) begin
        issues++;
        check("loop body instr", out_instr, I0);
      end
      @(negedge clk);
      #1;
      cycles++;
    end
    check("loop left ucode in bound", {31'h0, ucode_flag}, 32'h0);
    check("loop body issues", issues, exp_issues);
    check("loop ucode cycles", cycles, 2 * exp_issues + 1);
    check("loop pc after", program_counter, exp_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = UEND;
    macro_opc_tbl   = {7'h01, 7'h11, 7'h10, 7'h01};
    macro_entry_tbl = {5'd20, 5'd12, 5'd5, 5'd3};

    //              instr   v  rdy ovr off       pc        uaddr  val instr  chk flag
    vecs[0]  = mk(ADD,    1, 1, 0, 16'h0,    32'h00,  5'd0, 0, 32'h0,  1, 0); // S_IDLE
    vecs[1]  = mk(ADD,    1, 1, 0, 16'h0,    32'h00,  5'd0, 1, ADD,    1, 0);
    vecs[2]  = mk(ADD,    1, 1, 0, 16'h0,    32'h04,  5'd0, 1, ADD,    1, 0);
    vecs[3]  = mk(ADD,    1, 1, 0, 16'h0,    32'h08,  5'd0, 1, ADD,    1, 0);
    vecs[4]  = mk(ADD,    1, 1, 0, 16'h0,    32'h0C,  5'd0, 1, ADD,    1, 0);
    vecs[5]  = mk(MACRO1, 1, 0, 0, 16'h0,    32'h10,  5'd0, 0, MACRO1, 1, 0);
    vecs[6]  = mk(ADD,    0, 0, 0, 16'h0,    32'h14,  5'd5, 1, I0,     1, 1); // stalled
    vecs[7]  = mk(ADD,    0, 1, 0, 16'h0,    32'h14,  5'd5, 1, I0,     1, 1);
    vecs[8]  = mk(ADD,    0, 1, 0, 16'h0,    32'h14,  5'd6, 1, I1_EXP, 1, 1);
    vecs[9]  = mk(ADD,    0, 1, 0, 16'h0,    32'h14,  5'd7, 0, 32'h0,  0, 1); // END
    vecs[10] = mk(ADD,    1, 1, 0, 16'h0,    32'h14,  5'd7, 1, ADD,    1, 0);
    vecs[11] = mk(ADD,    1, 1, 0, 16'h0,    32'h18,  5'd7, 1, ADD,    1, 0);
    vecs[12] = mk(ADD,    1, 1, 0, 16'h0,    32'h1C,  5'd7, 1, ADD,    1, 0);
    vecs[13] = mk(BR,     1, 0, 0, 16'h0,    32'h20,  5'd7, 1, BR,     1, 0);
    vecs[14] = mk(BR,     1, 0, 0, 16'h0,    32'h20,  5'd7, 1, BR,     1, 0);
    vecs[15] = mk(BR,     1, 0, 0, 16'h0,    32'h20,  5'd7, 1, BR,     1, 0);
    vecs[16] = mk(BR,     1, 1, 0, 16'h0,    32'h20,  5'd7, 1, BR,     1, 0);
    vecs[17] = mk(ADD,    0, 1, 0, 16'h0,    32'h1C,  5'd7, 0, ADD,    1, 0);
    vecs[18] = mk(ADD,    1, 1, 1, 16'h0010, 32'h1C,  5'd7, 0, ADD,    1, 0);
    vecs[19] = mk(ADD,    1, 1, 0, 16'h0,    32'h2C,  5'd7, 1, ADD,    1, 0);

    rom[5] = I0; rom[6] = I1; rom[7] = UEND;

    rst = 1'b1;
    imem_instr = ADD; imem_valid = 1'b0; out_ready = 1'b0;
    exe_override = 1'b0; exe_offset = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset pc", program_counter, 32'h0);
    check("reset uaddr", {27'h0, ucode_addr}, 32'h0);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset out_instr", out_instr, 32'h0);
    check("reset macro fields", {8'h0, macro_rd, macro_rs, macro_imm}, 32'h0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst          = 1'b0;
      imem_instr   = vecs[i].instr;
      imem_valid   = vecs[i].valid;
      out_ready    = vecs[i].ready;
      exe_override = vecs[i].ovr;
      exe_offset   = vecs[i].off;
      #1;
      check($sformatf("v%0d pc", i), program_counter, vecs[i].e_pc);
      check($sformatf("v%0d uaddr", i), {27'h0, ucode_addr}, {27'h0, vecs[i].e_uaddr});
      check($sformatf("v%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].e_valid});
      check($sformatf("v%0d ucode_flag", i), {31'h0, ucode_flag}, {31'h0, vecs[i].e_flag});
      if (vecs[i].e_chk) check($sformatf("v%0d out_instr", i), out_instr, vecs[i].e_instr);
    end

    // Counted loops: count 2 runs the body three times, count 0 once.
    run_loop(8'd2, 3, 32'h34);
    run_loop(8'd0, 1, 32'h38);

    // Negative execute redirect in fetch: 0x38 - 0x28 = 0x10.
    @(negedge clk);
    imem_instr = ADD; imem_valid = 1'b1; out_ready = 1'b1;
    exe_override = 1'b1; exe_offset = 16'hFFD8;
    #1;
    check("fetch override out_valid", {31'h0, out_valid}, 32'h0);

    // Abort during the second ucode instruction.
    rom[5] = I0; rom[6] = I1; rom[7] = UEND;
    @(negedge clk);
    exe_override = 1'b0; imem_instr = MACRO1; imem_valid = 1'b1;
    #1;
    check("redirect pc", program_counter, 32'h10);
    @(negedge clk);
    imem_valid = 1'b0;
    #1;
    check("abort seq pc", program_counter, 32'h14);
    check("macro fields", {8'h0, macro_rd, macro_rs, macro_imm}, 32'h0035_1234);
    check("abort seq first instr", out_instr, I0);
    @(negedge clk);
    exe_override = 1'b1; exe_offset = 16'h0010;
    #1;
    check("abort uaddr", {27'h0, ucode_addr}, 32'd6);
    check("abort out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    exe_override = 1'b0; imem_instr = ADD; imem_valid = 1'b1;
    #1;
    check("abort pc", program_counter, 32'h24);
    check("abort back to fetch", {31'h0, ucode_flag}, 32'h0);
    check("abort fetch valid", {31'h0, out_valid}, 32'h1);

    // Asynchronous reset while the loop counter is active.
    rom[3] = I0; rom[4] = 32'hE000_0203; rom[5] = UEND;
    @(negedge clk);
    imem_instr = MACRO0; imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre-reset in loop", {27'h0, ucode_addr}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async rst pc", program_counter, 32'h0);
    check("async rst uaddr", {27'h0, ucode_addr}, 32'h0);
    check("async rst out_valid", {31'h0, out_valid}, 32'h0);
    check("async rst out_instr", out_instr, 32'h0);
    check("async rst ucode_flag", {31'h0, ucode_flag}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset idle valid", {31'h0, out_valid}, 32'h0);
    run_loop(8'd2, 3, 32'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch_ucode_seq.md
Name: ifetch_ucode_seq

Overview:
Parametrised instruction-fetch stage with a microcode sequencer. It issues sequential and branch PCs and forwards fetched instructions downstream over a valid/ready handshake. Macro opcodes, from a run-time table of N_MACRO entries, are expanded into sequences read from an external microcode ROM. Sequences support a counted loop and an end marker; a resolved branch from execute can abort a sequence. It sits between instruction memory / ucode ROM and decode.

Parameters:
PC_W, 32, program counter width
UADDR_W, 5, ucode ROM address width (depth 2^UADDR_W)
N_MACRO, 4, number of macro opcodes expanded
IMM_W, 16, width of branch offsets from imem and execute

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_instr  in  32  instruction at program_counter
imem_valid  in  1  imem_instr valid
program_counter  out  PC_W  fetch address
ucode_addr  out  UADDR_W  ucode ROM address
ucode_instr  in  32  ROM data for ucode_addr, same cycle
macro_opc_tbl  in  7*N_MACRO  macro opcodes; entry i at [7i+6:7i]
macro_entry_tbl  in  UADDR_W*N_MACRO  ROM entry address per macro
exe_override  in  1  branch resolved taken in execute
exe_offset  in  IMM_W  signed offset for exe_override
out_instr  out  32  instruction to decode
out_valid  out  1  out_instr valid
out_ready  in  1  decode accepts
ucode_flag  out  1  high while in S_UCODE
macro_rd, macro_rs  out  4 each  latched [24:21], [20:17] of macro
macro_imm  out  16  latched [15:0] of macro

Behaviour:
- Reset (async): program_counter=0, ucode_addr=0, state=S_IDLE, macro_rd/rs/imm=0, loop_cnt=0, loop_busy=0. Combinational outputs evaluate in S_IDLE to out_valid=0, out_instr=0, ucode_flag=0.
- S_IDLE: out_valid=0; always goes to S_FETCH next cycle.
- S_FETCH, combinational: out_instr=imem_instr; out_valid=imem_valid, forced 0 if exe_override or the instruction is a macro.
- Macro match: imem_valid and imem_instr[31:25] equals any table entry. Lowest index wins on duplicate entries.
- S_FETCH, sequential, in priority order:
  (1) exe_override: pc += sext(exe_offset); no other action.
  (2) Macro match: latch macro_rd/rs/imm; ucode_addr<=entry; pc+=4; go to S_UCODE. out_ready is not required.
  (3) Fire (imem_valid & out_ready):
    - B ([31:30]=11, [28:25]=0000): pc += 4 + sext(imm[15:0]).
    - Otherwise, NOP included: pc += 4.
  (4) Else hold the PC.
- All PC arithmetic is modulo 2^PC_W.
- S_UCODE: ucode_flag=1. ucode_instr is classified by [31:28]:
  - 1101 END: out_valid=0; next cycle S_FETCH; loop_busy<=0.
  - 1110 LOOP: out_valid=0. Target is [UADDR_W-1:0]; count is [15:8].
    - If !loop_busy and count≠0: loop_busy<=1, loop_cnt<=count-1, jump to target.
    - If loop_busy and loop_cnt≠0: loop_cnt--, jump.
    - Otherwise (including count=0): loop_busy<=0, ucode_addr+1.
    - Net effect: the body runs count+1 times. Nested loops are unsupported; an inner LOOP reuses the same counter.
  - Other: out_instr=ucode_instr, out_valid=1. On out_ready, ucode_addr+1; otherwise hold.
- ucode_addr wraps modulo 2^UADDR_W.
- exe_override in S_UCODE: abort the sequence. pc += sext(exe_offset), out_valid=0, loop_busy<=0, next cycle S_FETCH.
- Reset mid-sequence: immediate return to S_IDLE with all registers at reset values.
- Latency: a macro is detected in cycle N and the first ucode instruction is presented in cycle N+1. After END, the next fetched instruction is presented one cycle later.

Optional Feature:
UCODE_OPERAND_SUBST_EN
- Defined: in S_UCODE, forwarded instructions have out_instr[24:21] replaced by macro_rd when that field is 4'hF, and [20:17] replaced by macro_rs when 4'hF. out_instr[15:0] is replaced by macro_imm when [16] is 1.
- Undefined: ucode instructions are forwarded unmodified.

Test Plan:
- Reset, then imem returns ADD every cycle with out_ready=1 -> PC 0,4,8,12; out_valid=1 from cycle 2.
- B with imm=0xFFF8 at PC 0x20 -> next PC 0x1C. out_ready=0 for 3 cycles -> PC and out_instr held.
- Macro opcode 0010000 (entry 1, entry address 5) at PC 0x10; ROM 5=I0, 6=I1, 7=END -> I0, I1 forwarded with ucode_flag=1, then PC 0x14 fetched.
- ROM 3=I0, 4=LOOP(target 3, count 2), 5=END -> I0 issued 3 times, then return to S_FETCH.
- exe_override with exe_offset=0x0010 during the 2nd ucode instruction, PC 0x14 -> PC 0x24, out_valid=0, S_FETCH next cycle; async rst mid-LOOP -> all outputs at reset values.
- With UCODE_OPERAND_SUBST_EN: macro rd=3 and ucode rd field F -> forwarded [24:21]=3.
